// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code to per-key event decoder.
// Turns the receiver byte stream into press/release pulses and held levels
// for a parameterised key table. Handles E0 (extended), F0 (break), the E1
// pause sequence and a stale-prefix timeout.
// Optional internal auto-repeat is built when KEY_AUTO_REPEAT_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for a prefix or a plain make code
// EXT     | E0 seen, next code is extended
// BRK     | F0 seen, next code is a plain break
// EXT_BRK | E0 F0 seen, next code is an extended break
// PAUSE   | E1 seen, swallowing the rest of the pause sequence
module ps2_key_event_decoder #(
  parameter int                    NUM_KEYS       = 8,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {9'h15A, 9'h029, 9'h02D, 9'h04D,
                                                     9'h172, 9'h175, 9'h174, 9'h16B},
  parameter int                    TIMEOUT_CYCLES = 2_500_000,
  parameter int                    REPEAT_DELAY   = 25_000_000,
  parameter int                    REPEAT_PERIOD  = 5_000_000
) (
  input  logic                CLK_50M,
  input  logic                RST_N,
  input  logic [7:0]          ps2_byte,
  input  logic                ps2_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                unknown_code,
  output logic [8:0]          last_code
);

  localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int GW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;

  state_t              r_state, w_next;
  logic                r_ps2, r_ps2_d;
  logic [GW-1:0]       r_gap;
  logic [2:0]          r_skip;
  logic                w_byte_stb;
  logic                w_done, w_make, w_ext;
  logic [8:0]          w_code;
  logic                w_hit;
  logic [IW-1:0]       w_idx;
  logic                w_press_evt, w_rel_evt;
  logic [NUM_KEYS-1:0] w_rep_vec;

  assign w_byte_stb  = r_ps2 & ~r_ps2_d;
  assign w_code      = {w_ext, ps2_byte};
  assign w_press_evt = w_done & w_make & w_hit & ~key_held[w_idx];
  assign w_rel_evt   = w_done & ~w_make & w_hit & key_held[w_idx];

  // register the byte-valid level and delay it for edge detection
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_ps2   <= 1'b0;
      r_ps2_d <= 1'b0;
    end else begin
      r_ps2   <= ps2_state;
      r_ps2_d <= r_ps2;
    end
  end

  // next-state decode and classification of the completed code
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_make = 1'b0;
    w_ext  = 1'b0;
    if (w_byte_stb) begin
      case (r_state)
        S_IDLE: begin
          if (ps2_byte == 8'hE0)      w_next = S_EXT;
          else if (ps2_byte == 8'hF0) w_next = S_BRK;
          else if (ps2_byte == 8'hE1) w_next = S_PAUSE;
          else begin
            w_done = 1'b1;
            w_make = 1'b1;
          end
        end
        S_EXT: begin
          w_ext = 1'b1;
          if (ps2_byte == 8'hF0) w_next = S_EXT_BRK;
          else if (ps2_byte != 8'hE0 && ps2_byte != 8'hE1) begin
            w_done = 1'b1;
            w_make = 1'b1;
            w_next = S_IDLE;
          end
        end
        S_BRK: begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
        S_EXT_BRK: begin
          w_ext  = 1'b1;
          w_done = 1'b1;
          w_next = S_IDLE;
        end
        S_PAUSE: begin
          if (r_skip <= 3'd1) w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end else if (r_state != S_IDLE && r_gap == GAP_MAX) begin
      w_next = S_IDLE;
    end
  end

  // parallel table match; iterating downwards lets the lowest index win
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEY_CODES[9*i +: 9] == w_code) begin
        w_hit = 1'b1;
        w_idx = IW'(i);
      end
    end
  end

  // state register, prefix gap timer and pause byte counter
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_gap   <= '0;
      r_skip  <= '0;
    end else begin
      r_state <= w_next;
      if (w_byte_stb || w_next == S_IDLE) r_gap <= '0;
      else if (r_gap != GAP_MAX)          r_gap <= r_gap + 1'b1;
      if (r_state == S_IDLE && w_next == S_PAUSE)       r_skip <= 3'd7;
      else if (r_state == S_PAUSE && w_byte_stb && r_skip != 3'd0) r_skip <= r_skip - 1'b1;
    end
  end

  // event pulses, held levels and last complete code
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      key_press    <= '0;
      key_release  <= '0;
      key_held     <= '0;
      unknown_code <= 1'b0;
      last_code    <= '0;
    end else begin
      key_press    <= w_rep_vec;
      key_release  <= '0;
      unknown_code <= 1'b0;
      if (w_done) begin
        last_code <= w_code;
        if (!w_hit) unknown_code <= 1'b1;
        else if (w_press_evt) begin
          key_held[w_idx]  <= 1'b1;
          key_press[w_idx] <= 1'b1;
        end else if (w_rel_evt) begin
          key_held[w_idx]    <= 1'b0;
          key_release[w_idx] <= 1'b1;
        end
      end
    end
  end

`ifdef KEY_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;

  logic          r_rep_on;
  logic [IW-1:0] r_rep_idx;
  logic [RW-1:0] r_rep_cnt;

  // fire when the tracked key's down-counter hits zero, unless it is being released now
  always_comb begin
    w_rep_vec = '0;
    if (r_rep_on && r_rep_cnt == '0 && key_held[r_rep_idx] &&
        !(w_rel_evt && w_idx == r_rep_idx))
      w_rep_vec[r_rep_idx] = 1'b1;
  end

  // single tracker following the most recent press
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_rep_on  <= 1'b0;
      r_rep_idx <= '0;
      r_rep_cnt <= '0;
    end else if (w_press_evt) begin
      r_rep_on  <= 1'b1;
      r_rep_idx <= w_idx;
      r_rep_cnt <= RW'(REPEAT_DELAY - 1);
    end else if (r_rep_on) begin
      if (w_rel_evt && w_idx == r_rep_idx) r_rep_on  <= 1'b0;
      else if (r_rep_cnt == '0)            r_rep_cnt <= RW'(REPEAT_PERIOD - 1);
      else                                 r_rep_cnt <= r_rep_cnt - 1'b1;
    end
  end
`else
  logic [1:0] w_unused_rep;
  assign w_unused_rep = {REPEAT_DELAY[0], REPEAT_PERIOD[0]};
  assign w_rep_vec    = '0;
`endif

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench for ps2_key_event_decoder (small timeout / repeat values).
module tb_ps2_key_event_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ps2_byte = 8'h00;
  logic       ps2_state = 1'b0;
  logic [7:0] key_press, key_release, key_held;
  logic       unknown_code;
  logic [8:0] last_code;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] c1_press, c2_press, c3_press, c2_rel, c3_rel;
  logic       c1_unk, c2_unk, c3_unk;
  logic [7:0] acc_ev;
  logic [31:0] cyc = 0;
  logic [31:0] q_rep[$];
  logic [31:0] p0;

  ps2_key_event_decoder #(
    .NUM_KEYS(8),
    .TIMEOUT_CYCLES(16),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(5)
  ) dut (
    .CLK_50M(clk),
    .RST_N(rst_n),
    .ps2_byte(ps2_byte),
    .ps2_state(ps2_state),
    .key_press(key_press),
    .key_release(key_release),
    .key_held(key_held),
    .unknown_code(unknown_code),
    .last_code(last_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (key_press[6]) q_rep.push_back(cyc);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ps2_byte  = b;
    ps2_state = 1'b1;
    @(posedge clk); #1;
    c1_press = key_press; c1_unk = unknown_code;
    @(posedge clk); #1;
    c2_press = key_press; c2_rel = key_release; c2_unk = unknown_code;
    @(posedge clk); #1;
    c3_press = key_press; c3_rel = key_release; c3_unk = unknown_code;
    @(negedge clk);
    ps2_state = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    check("rst_held",  32'(key_held), 32'h00);
    check("rst_press", 32'(key_press), 32'h00);
    check("rst_rel",   32'(key_release), 32'h00);
    check("rst_unk",   32'(unknown_code), 32'h0);
    check("rst_last",  32'(last_code), 32'h000);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // E0 6B: left make
    send_byte(8'hE0);
    check("e0_no_press", 32'(c2_press), 32'h00);
    send_byte(8'h6B);
    check("left_edge1",  32'(c1_press), 32'h00);
    check("left_press",  32'(c2_press), 32'h01);
    check("left_1cyc",   32'(c3_press), 32'h00);
    check("left_held",   32'(key_held), 32'h01);
    check("left_last",   32'(last_code), 32'h16B);

    // typematic make suppressed
    send_byte(8'hE0); send_byte(8'h6B);
    check("typematic_press", 32'(c2_press), 32'h00);
    check("typematic_unk",   32'(c2_unk), 32'h0);

    // E0 F0 6B: left break
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    check("left_release", 32'(c2_rel), 32'h01);
    check("left_rel_1cyc", 32'(c3_rel), 32'h00);
    check("left_unheld",  32'(key_held), 32'h00);

    // left again, then P (index 4)
    send_byte(8'hE0); send_byte(8'h6B);
    check("left_press2", 32'(c2_press), 32'h01);
    send_byte(8'h4D);
    check("p_press", 32'(c2_press), 32'h10);
    check("p_held",  32'(key_held), 32'h11);
    check("p_last",  32'(last_code), 32'h04D);

    // unknown code
    send_byte(8'h1C);
    check("unk_pulse", 32'(c2_unk), 32'h1);
    check("unk_1cyc",  32'(c3_unk), 32'h0);
    check("unk_held",  32'(key_held), 32'h11);
    check("unk_last",  32'(last_code), 32'h01C);

    // stale E0 prefix times out
    send_byte(8'hE0);
    repeat (30) @(negedge clk);
    send_byte(8'h6B);
    check("tmo_unk",   32'(c2_unk), 32'h1);
    check("tmo_press", 32'(c2_press), 32'h00);
    check("tmo_last",  32'(last_code), 32'h06B);

    // pause sequence is swallowed
    acc_ev = 8'h00;
    send_byte(8'hE1); acc_ev = acc_ev | c2_press | c2_rel | {7'd0, c2_unk};
    send_byte(8'h14); acc_ev = acc_ev | c2_press | c2_rel | {7'd0, c2_unk};
    send_byte(8'h77); acc_ev = acc_ev | c2_press | c2_rel | {7'd0, c2_unk};
    send_byte(8'hE1); acc_ev = acc_ev | c2_press | c2_rel | {7'd0, c2_unk};
    send_byte(8'hF0); acc_ev = acc_ev | c2_press | c2_rel | {7'd0, c2_unk};
    send_byte(8'h14); acc_ev = acc_ev | c2_press | c2_rel | {7'd0, c2_unk};
    send_byte(8'hF0); acc_ev = acc_ev | c2_press | c2_rel | {7'd0, c2_unk};
    send_byte(8'h77); acc_ev = acc_ev | c2_press | c2_rel | {7'd0, c2_unk};
    check("pause_quiet", 32'(acc_ev), 32'h00);
    check("pause_held",  32'(key_held), 32'h11);
    check("pause_last",  32'(last_code), 32'h06B);

    // back in IDLE: plain 5A is unknown, E0 5A is enter
    send_byte(8'h5A);
    check("plain5a_unk",  32'(c2_unk), 32'h1);
    check("plain5a_last", 32'(last_code), 32'h05A);
    send_byte(8'hE0); send_byte(8'h5A);
    check("enter_press", 32'(c2_press), 32'h80);
    check("enter_held",  32'(key_held), 32'h91);
    check("enter_last",  32'(last_code), 32'h15A);

    // break of a key that is not held
    send_byte(8'hF0); send_byte(8'h29);
    check("brk_unheld_rel", 32'(c2_rel), 32'h00);
    check("brk_unheld_unk", 32'(c2_unk), 32'h0);
    check("brk_unheld_last", 32'(last_code), 32'h029);

    // E1 inside EXT is ignored
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    check("left_rel2", 32'(c2_rel), 32'h01);
    send_byte(8'hE0); send_byte(8'hE1); send_byte(8'h6B);
    check("ext_e1_press", 32'(c2_press), 32'h01);
    check("ext_e1_held",  32'(key_held), 32'h91);

    // space held: auto-repeat when enabled, nothing more otherwise
    q_rep.delete();
    send_byte(8'h29);
    check("space_press", 32'(c2_press), 32'h40);
    check("space_held",  32'(key_held), 32'hD1);
    p0 = (q_rep.size() > 0) ? q_rep[0] : cyc;
    while (cyc < p0 + 26) @(negedge clk);
    send_byte(8'hF0); send_byte(8'h29);
    check("space_release", 32'(c2_rel), 32'h40);
    repeat (20) @(negedge clk);
`ifdef KEY_AUTO_REPEAT_EN
    check("rep_count", 32'(q_rep.size()), 32'd4);
    if (q_rep.size() == 4) begin
      check("rep_1st", q_rep[1] - q_rep[0], 32'd20);
      check("rep_2nd", q_rep[2] - q_rep[0], 32'd25);
      check("rep_3rd", q_rep[3] - q_rep[0], 32'd30);
    end
`else
    check("no_repeat", 32'(q_rep.size()), 32'd1);
`endif

    // reset mid-sequence (after F0) and decode the next byte from IDLE
    send_byte(8'h29);
    check("space_press2", 32'(c2_press), 32'h40);
    send_byte(8'hF0);
    @(negedge clk); rst_n = 1'b0; #1;
    check("midrst_held", 32'(key_held), 32'h00);
    check("midrst_last", 32'(last_code), 32'h000);
    check("midrst_press", 32'(key_press), 32'h00);
    repeat (2) @(negedge clk); rst_n = 1'b1;
    send_byte(8'h29);
    check("postrst_press", 32'(c2_press), 32'h40);
    check("postrst_rel",   32'(c2_rel), 32'h00);
    check("postrst_held",  32'(key_held), 32'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
